// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receiver.
//   - rx_state_e      receiver FSM states
//   - DIV_*           16x oversample divisors (50 MHz clock)
//   - PAR_*           parity_type encodings
//   - ERR_*           error_flag bit indices
//   - baud_divisor()  divisor lookup, optionally scaled down by a right shift
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned DIV_W     = 11;
    localparam int unsigned DIV_2400  = 1302;
    localparam int unsigned DIV_4800  = 651;
    localparam int unsigned DIV_9600  = 326;
    localparam int unsigned DIV_19200 = 163;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam int ERR_PARITY      = 0;
    localparam int ERR_FALSE_START = 1;
    localparam int ERR_STOP        = 2;

    // Tick index (0-based) of the mid-bit sample in the start bit, and of
    // the sample point for every following bit (one full bit later).
    localparam logic [3:0] START_SAMPLE_TICK = 4'd7;
    localparam logic [3:0] BIT_SAMPLE_TICK   = 4'd15;

    // A non-zero shift divides every divisor by 2**shift; the shipped
    // configuration uses shift 0. The shift must keep the divisor >= 1.
    function automatic logic [DIV_W-1:0] baud_divisor(input logic [1:0] rate,
                                                     input int unsigned shift);
        int unsigned d;
        case (rate)
            2'b00:   d = DIV_2400;
            2'b01:   d = DIV_4800;
            2'b10:   d = DIV_9600;
            default: d = DIV_19200;
        endcase
        return DIV_W'(d >> shift);
    endfunction

    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x oversample tick generator.
//   clock      system clock
//   reset      synchronous active-high reset
//   baud_rate  rate select (00=2400, 01=4800, 10=9600, 11=19200)
//   restart    holds the divisor counter at 0 while high
//   tick       one-cycle pulse each time the divisor counter wraps
module uart_baud_gen
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV_SHIFT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] baud_rate,
    input  logic       restart,
    output logic       tick
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_last;

    assign div_last = baud_divisor(baud_rate, DIV_SHIFT) - DIV_W'(1);

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == div_last) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8-bit UART receiver with optional parity.
//   clock        system clock (50 MHz)
//   reset        synchronous active-high reset
//   baud_rate    00=2400, 01=4800, 10=9600, 11=19200 (latched at frame start)
//   parity_type  01=odd, 10=even, 00/11=none (latched at frame start)
//   rx_line      asynchronous serial input, idle high
//   rx_data      last received byte
//   rx_done      one-cycle pulse when a frame completes
//   rx_busy      high while a frame is in progress
//   error_flag   bit0 parity, bit1 false start, bit2 stop/framing
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a synchronized falling edge on rx_line
// ST_START  | validating the start bit at its midpoint (tick 8)
// ST_DATA   | sampling 8 data bits LSB-first, one every 16 ticks
// ST_PARITY | sampling and checking the parity bit
// ST_STOP   | sampling the stop bit, publishing the byte, back to idle
module uart_rx_unit
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV_SHIFT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic [2:0] error_flag
);

    rx_state_e  state;
    logic       rx_s1, rx_s2, rx_prev;
    logic [1:0] baud_q;
    logic [1:0] parity_q;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       tick;
    logic       restart;

    // Holding the divisor in reset throughout IDLE means it starts counting
    // from 0 on the first START cycle, phase-aligned to the start edge.
    assign restart = (state == ST_IDLE);

    uart_baud_gen #(
        .DIV_SHIFT (DIV_SHIFT)
    ) u_baud_gen (
        .clock     (clock),
        .reset     (reset),
        .baud_rate (baud_q),
        .restart   (restart),
        .tick      (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            baud_q     <= 2'b00;
            parity_q   <= PAR_NONE;
            tick_cnt   <= 4'd0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            rx_data    <= 8'h00;
            rx_done    <= 1'b0;
            rx_busy    <= 1'b0;
            error_flag <= 3'b000;
        end else begin
            rx_s1   <= rx_line;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        state      <= ST_START;
                        rx_busy    <= 1'b1;
                        error_flag <= 3'b000;
                        baud_q     <= baud_rate;
                        parity_q   <= parity_type;
                        tick_cnt   <= 4'd0;
                        bit_cnt    <= 3'd0;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (tick_cnt == START_SAMPLE_TICK) begin
                            // Restart the tick count so later samples land
                            // a whole bit period after this mid-bit point.
                            tick_cnt <= 4'd0;
                            if (rx_s2) begin
                                error_flag[ERR_FALSE_START] <= 1'b1;
                                rx_busy <= 1'b0;
                                state   <= ST_IDLE;
                            end else begin
                                state <= ST_DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == BIT_SAMPLE_TICK) begin
                            shift_reg <= {rx_s2, shift_reg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                state   <= parity_enabled(parity_q) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == BIT_SAMPLE_TICK) begin
                            // Total ones over data+parity is odd for odd
                            // parity and even for even parity.
                            error_flag[ERR_PARITY] <=
                                ((^shift_reg) ^ rx_s2) != (parity_q == PAR_ODD);
                            state <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == BIT_SAMPLE_TICK) begin
                            if (!rx_s2) begin
                                error_flag[ERR_STOP] <= 1'b1;
                            end
                            rx_data <= shift_reg;
                            rx_done <= 1'b1;
                            rx_busy <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: directed, table-driven bench for uart_rx_unit.
// The receiver runs with divisors scaled down by 2**SHIFT to keep frames
// short; a separate full-scale uart_baud_gen checks the real divisors.
module tb_uart_rx_unit;

    localparam int unsigned SHIFT = 4;

    logic       clock;
    logic       reset;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic [2:0] error_flag;

    logic [1:0] bg_rate;
    logic       bg_restart;
    logic       bg_tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_data[$];
    logic [2:0] cap_err[$];

    uart_rx_unit #(
        .DIV_SHIFT (SHIFT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .baud_rate   (baud_rate),
        .parity_type (parity_type),
        .rx_line     (rx_line),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_busy     (rx_busy),
        .error_flag  (error_flag)
    );

    uart_baud_gen #(
        .DIV_SHIFT (0)
    ) bg (
        .clock     (clock),
        .reset     (reset),
        .baud_rate (bg_rate),
        .restart   (bg_restart),
        .tick      (bg_tick)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Every cycle rx_done is high counts as a separate completion, so a
    // pulse longer than one clock shows up as an extra captured frame.
    always @(negedge clock) begin
        if (rx_done) begin
            cap_data.push_back(rx_data);
            cap_err.push_back(error_flag);
        end
    end

    typedef struct {
        logic [1:0] baud;
        logic [1:0] par;
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        logic [7:0] exp_data;
        logic [2:0] exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bit_cycles(input logic [1:0] b);
        case (b)
            2'b00:   return (1302 >> SHIFT) * 16;
            2'b01:   return (651 >> SHIFT) * 16;
            2'b10:   return (326 >> SHIFT) * 16;
            default: return (163 >> SHIFT) * 16;
        endcase
    endfunction

    task automatic hold_line(input logic v, input int cycles);
        rx_line = v;
        repeat (cycles) @(negedge clock);
    endtask

    // Drives one frame at rate b. With chg set, the DUT configuration inputs
    // are changed halfway through the start bit; the line timing is unchanged.
    task automatic send_frame(input logic [1:0] b, input logic [1:0] p, input logic [7:0] d,
                              input logic pbit, input logic stop, input int idle_bits,
                              input logic chg);
        int bc;
        bc = bit_cycles(b);
        hold_line(1'b0, bc / 2);
        if (chg) begin
            baud_rate   = 2'b11;
            parity_type = 2'b00;
        end
        hold_line(1'b0, bc - bc / 2);
        for (int i = 0; i < 8; i++) hold_line(d[i], bc);
        if (p == 2'b01 || p == 2'b10) hold_line(pbit, bc);
        hold_line(stop, bc);
        hold_line(1'b1, idle_bits * bc);
    endtask

    function automatic int unsigned cap_d(input int idx);
        return (cap_data.size() > idx) ? int'(cap_data[idx]) : 32'hFFFF;
    endfunction

    function automatic int unsigned cap_e(input int idx);
        return (cap_err.size() > idx) ? int'(cap_err[idx]) : 32'hFFFF;
    endfunction

    initial begin
        int exp_div[4];
        int n;

        vecs[0] = '{2'b10, 2'b01, 8'h2B, 1'b1, 1'b1, 8'h2B, 3'b000};
        vecs[1] = '{2'b11, 2'b10, 8'hA5, 1'b0, 1'b1, 8'hA5, 3'b000};
        vecs[2] = '{2'b11, 2'b10, 8'hA5, 1'b1, 1'b1, 8'hA5, 3'b001};
        vecs[3] = '{2'b00, 2'b00, 8'h3C, 1'b0, 1'b0, 8'h3C, 3'b100};
        vecs[4] = '{2'b01, 2'b01, 8'h00, 1'b0, 1'b1, 8'h00, 3'b001};
        vecs[5] = '{2'b10, 2'b11, 8'hC3, 1'b0, 1'b1, 8'hC3, 3'b000};
        vecs[6] = '{2'b01, 2'b10, 8'h80, 1'b0, 1'b0, 8'h80, 3'b101};
        exp_div = '{1302, 651, 326, 163};

        reset       = 1'b1;
        rx_line     = 1'b1;
        baud_rate   = 2'b00;
        parity_type = 2'b00;
        bg_rate     = 2'b00;
        bg_restart  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset outputs", {rx_data, rx_done, rx_busy, error_flag}, 13'h0000);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Full-scale divisor periods.
        for (int r = 0; r < 4; r++) begin
            bg_rate    = 2'(r);
            bg_restart = 1'b1;
            @(negedge clock);
            bg_restart = 1'b0;
            n = 0;
            while (!bg_tick && n < 3000) begin
                @(negedge clock);
                n++;
            end
            @(negedge clock);
            n = 1;
            while (!bg_tick && n < 3000) begin
                @(negedge clock);
                n++;
            end
            check($sformatf("tick period rate%0d", r), n, exp_div[r]);
        end

        // Table of complete frames.
        for (int i = 0; i < 7; i++) begin
            baud_rate   = vecs[i].baud;
            parity_type = vecs[i].par;
            cap_data.delete();
            cap_err.delete();
            send_frame(vecs[i].baud, vecs[i].par, vecs[i].data, vecs[i].pbit,
                       vecs[i].stop, 2, 1'b0);
            check($sformatf("vec%0d done count", i), cap_data.size(), 1);
            check($sformatf("vec%0d rx_data", i), cap_d(0), vecs[i].exp_data);
            check($sformatf("vec%0d err at done", i), cap_e(0), vecs[i].exp_err);
            check($sformatf("vec%0d err held", i), error_flag, vecs[i].exp_err);
            check($sformatf("vec%0d busy idle", i), rx_busy, 0);
        end

        // False start at 4800: line low for 4 ticks only.
        baud_rate   = 2'b01;
        parity_type = 2'b00;
        cap_data.delete();
        cap_err.delete();
        rx_line = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clock);
            n++;
        end
        check("false start busy", rx_busy, 1);
        repeat (4 * (651 >> SHIFT) - 20) begin
            @(negedge clock);
            n++;
        end
        rx_line = 1'b1;
        while (rx_busy && n < 9 * (651 >> SHIFT)) begin
            @(negedge clock);
            n++;
        end
        check("false start busy drop", rx_busy, 0);
        hold_line(1'b1, 2 * bit_cycles(2'b01));
        check("false start err", error_flag, 3'b010);
        check("false start no done", cap_data.size(), 0);
        check("false start data kept", rx_data, 8'h80);

        // Back-to-back at 19200.
        baud_rate   = 2'b11;
        parity_type = 2'b00;
        cap_data.delete();
        cap_err.delete();
        send_frame(2'b11, 2'b00, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        send_frame(2'b11, 2'b00, 8'hFF, 1'b0, 1'b1, 2, 1'b0);
        check("b2b done count", cap_data.size(), 2);
        check("b2b data0", cap_d(0), 8'h01);
        check("b2b data1", cap_d(1), 8'hFF);
        check("b2b err0", cap_e(0), 3'b000);
        check("b2b err1", cap_e(1), 3'b000);

        // Configuration changed mid-frame must not affect the frame.
        baud_rate   = 2'b10;
        parity_type = 2'b01;
        cap_data.delete();
        cap_err.delete();
        send_frame(2'b10, 2'b01, 8'h2B, 1'b1, 1'b1, 2, 1'b1);
        check("cfg change done count", cap_data.size(), 1);
        check("cfg change data", cap_d(0), 8'h2B);
        check("cfg change err", cap_e(0), 3'b000);

        // Reset during data bit 4 at 9600, then a clean 0x55 frame.
        baud_rate   = 2'b10;
        parity_type = 2'b00;
        cap_data.delete();
        cap_err.delete();
        hold_line(1'b0, bit_cycles(2'b10));
        for (int i = 0; i < 4; i++) hold_line(i[0] ? 1'b0 : 1'b1, bit_cycles(2'b10));
        hold_line(1'b1, 100);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("mid reset outputs", {rx_data, rx_done, rx_busy, error_flag}, 13'h0000);
        reset = 1'b0;
        hold_line(1'b1, 12 * bit_cycles(2'b10));
        check("mid reset no done", cap_data.size(), 0);
        check("mid reset busy", rx_busy, 0);
        send_frame(2'b10, 2'b00, 8'h55, 1'b0, 1'b1, 2, 1'b0);
        check("post reset done count", cap_data.size(), 1);
        check("post reset data", cap_d(0), 8'h55);
        check("post reset err", cap_e(0), 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_unit.md
UART_RX_UNIT -- requirements
Module: uart_rx_unit

Interface
REQ-001 The block SHALL use one clock and one reset; the reset is synchronous and active-high.
REQ-002 Port clock, input, 1 bit: system clock, 50 MHz.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port baud_rate, input, 2 bits: 00=2400, 01=4800, 10=9600, 11=19200 baud.
REQ-005 Port parity_type, input, 2 bits: 01=odd, 10=even, 00/11=no parity bit.
REQ-006 Port rx_line, input, 1 bit: asynchronous serial input, idle high.
REQ-007 Port rx_data, output, 8 bits: last received byte.
REQ-008 Port rx_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-009 Port rx_busy, output, 1 bit: high while a frame is in progress.
REQ-010 Port error_flag, output, 3 bits: bit0=parity error, bit1=false start, bit2=stop/framing error.

Function
REQ-011 rx_line SHALL pass through a 2-flop synchronizer before any use; this adds 2 cycles of latency.
REQ-012 The oversample tick SHALL be 16x the baud rate, with divisors 1302/651/326/163 for baud_rate 00/01/10/11; the tick is a one-cycle pulse each time the divisor counter wraps.
REQ-013 The divisor counter SHALL restart at 0 whenever the block leaves IDLE, so tick phase is aligned to the start edge.
REQ-014 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START on a synchronized falling edge of rx_line.
REQ-016 In START, the line SHALL be sampled at tick 8; if high, set error_flag[1], return to IDLE, and do not pulse rx_done; if low, go to DATA.
REQ-017 In DATA, one bit SHALL be sampled every 16 ticks; 8 bits are taken LSB-first into a shift register; a 3-bit bit counter ends the state after bit 7.
REQ-018 After DATA the FSM SHALL go to PARITY if parity_type is 01 or 10, else to STOP.
REQ-019 PARITY: parity error = (XOR of the data bits XOR the sampled bit) != expected, where expected is 1 for odd and 0 for even; the result goes to bit0.
REQ-020 STOP: the line SHALL be sampled once at mid-bit; if low, bit2 is set.
REQ-021 On the STOP sample, rx_data SHALL update, rx_done SHALL pulse for exactly one clock, and the FSM SHALL return to IDLE in the same cycle; the next start edge is accepted immediately.
REQ-022 error_flag SHALL be cleared on entry to START and hold its value until the next start edge.
REQ-023 rx_busy SHALL be high in every state except IDLE.
REQ-024 baud_rate and parity_type SHALL be sampled on entry to START and held for the frame; changes mid-frame have no effect until the next frame.
REQ-025 rx_data SHALL keep its previous value on a false start or a framing error, except that a frame with a framing error still updates rx_data and pulses rx_done.

Reset
REQ-026 While reset is high at a clock edge, the following SHALL hold: state=IDLE, rx_data=8'h00, rx_done=0, rx_busy=0, error_flag=3'b000, all counters=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_done; reception resumes on the first falling edge after reset deasserts.

Structure
REQ-028 Package uart_rx_pkg SHALL hold the state enum, the four divisor constants, the parity_type encodings, and the error_flag bit indices.
REQ-029 Sub-module uart_baud_gen (clock, reset, baud_rate, restart -> tick) SHALL produce the 16x tick; all other logic lives in uart_rx_unit.

Verification
REQ-030 9600 baud, odd parity, frame 0-11010100-1-1 (LSB first) -> rx_data=8'h2B, rx_done pulses once, error_flag=3'b000.
REQ-031 19200 baud, even parity, 8'hA5 with parity bit 0 -> rx_data=8'hA5, error_flag=3'b000; the same frame with parity bit 1 -> error_flag=3'b001.
REQ-032 2400 baud, no parity, 8'h3C with stop bit driven low -> rx_done pulses, rx_data=8'h3C, error_flag=3'b100.
REQ-033 4800 baud: rx_line low for 4 ticks then high -> no rx_done, error_flag=3'b010, rx_busy back to 0 within 9 ticks.
REQ-034 9600 baud, no parity: reset pulsed at data bit 4 -> all outputs at reset values, no rx_done; the next frame 8'h55 is received correctly.
REQ-035 19200 baud: two back-to-back frames 8'h01 then 8'hFF, with the second start bit directly after the first stop bit -> two rx_done pulses with the correct data, no errors.
